pair_serial_tx: RTL and testbench

- Serial transmitter: accepts a pair of bytes (z, x) over a load/ready handshake and shifts them out on the single-bit line f as one framed word.
- Transmit end of the one-bit-line / two-byte-bus link; the paired receiver rebuilds z and x from f.
- Frame: start bit, 16 data bits, parity bit, stop bit. Line idles high.

---
 rtl/pair_serial_tx_if.sv | 12 +
 rtl/pair_serial_tx.sv | 78 +++++++
 tb/tb_pair_serial_tx.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/pair_serial_tx_if.sv
// pair_serial_tx_if: load/ready handshake, byte pair and serial line of the pair transmitter
interface pair_serial_tx_if;
  logic       load;
  logic [7:0] z_in;
  logic [7:0] x_in;
  logic       ready;
  logic       busy;
  logic       done;
  logic       f;
  modport master(output load, z_in, x_in, input ready, busy, done, f);
  modport slave(input load, z_in, x_in, output ready, busy, done, f);
endinterface

// File: rtl/pair_serial_tx.sv
// pair_serial_tx: shifts a (z, x) byte pair out on f as start, 16 data, parity, stop bits
module pair_serial_tx #(
  parameter int CLKS_PER_BIT = 4,
  parameter bit PARITY_ODD   = 1'b0
) (
  input logic clk,
  input logic reset,
  pair_serial_tx_if.slave bus
);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  state_t      r_state, w_state_n;
  logic [7:0]  r_cnt, w_cnt_n;
  logic [4:0]  r_idx, w_idx_n;
  logic [15:0] r_sh, w_sh_n;
  logic        r_par, w_par_n, r_f, w_f_n, r_done, w_done_n, w_wrap;
  assign w_wrap = r_cnt == 8'(CLKS_PER_BIT - 1);
  // r_idx is the frame slot number; the DATA slots end after slot 16
  always_comb begin
    w_state_n = r_state;
    w_cnt_n   = (r_state == IDLE || w_wrap) ? 8'd0 : r_cnt + 8'd1;
    w_idx_n   = (r_state != IDLE && w_wrap) ? r_idx + 5'd1 : r_idx;
    w_sh_n    = r_sh;
    w_par_n   = r_par;
    w_f_n     = r_f;
    w_done_n  = 1'b0;
    case (r_state)
      IDLE: if (bus.load) begin
        w_state_n = START;
        w_sh_n    = {bus.x_in, bus.z_in};
        w_par_n   = (^{bus.x_in, bus.z_in}) ^ PARITY_ODD;
        w_f_n     = 1'b0;
        w_idx_n   = 5'd0;
      end
      START: if (w_wrap) begin
        w_state_n = DATA;
        w_f_n     = r_sh[0];
      end
      DATA: if (w_wrap) begin
        w_sh_n    = r_sh >> 1;
        w_f_n     = (r_idx == 5'd16) ? r_par : r_sh[1];
        w_state_n = (r_idx == 5'd16) ? PARITY : DATA;
      end
      PARITY: if (w_wrap) begin
        w_state_n = STOP;
        w_f_n     = 1'b1;
      end
      STOP: if (w_wrap) begin
        w_state_n = IDLE;
        w_done_n  = 1'b1;
        w_idx_n   = 5'd0;
      end
      default: w_state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_sh    <= '0;
      r_par   <= 1'b0;
      r_f     <= 1'b1;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_cnt   <= w_cnt_n;
      r_idx   <= w_idx_n;
      r_sh    <= w_sh_n;
      r_par   <= w_par_n;
      r_f     <= w_f_n;
      r_done  <= w_done_n;
    end
  end
  assign bus.ready = r_state == IDLE;
  assign bus.busy  = r_state != IDLE;
  assign bus.done  = r_done;
  assign bus.f     = r_f;
endmodule

// File: tb/tb_pair_serial_tx.sv
// tb_pair_serial_tx: scoreboard bench for two transmitters (C=4 even parity, C=1 odd parity)
module tb_pair_serial_tx;
  localparam int C0 = 4;
  localparam int C1 = 1;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  pair_serial_tx_if b0();
  pair_serial_tx_if b1();
  pair_serial_tx #(.CLKS_PER_BIT(C0), .PARITY_ODD(1'b0)) u0(.clk(clk), .reset(reset), .bus(b0));
  pair_serial_tx #(.CLKS_PER_BIT(C1), .PARITY_ODD(1'b1)) u1(.clk(clk), .reset(reset), .bus(b1));
  int n_chk = 0;
  int n_fail = 0;
  int cycle = 0;
  logic [18:0] q0[$];
  logic [18:0] q1[$];
  int n_done[2];
  bit active[2];
  int cyc[2];
  logic [18:0] bits[2];
  int t_done[3];
  int nd;
  function automatic logic [18:0] frame(logic [7:0] z, logic [7:0] x, bit odd);
    return {1'b1, (^{x, z}) ^ odd, x, z, 1'b0};
  endfunction
  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at cycle %0d", tag, got, exp, cycle);
    end
  endtask
  // expected frames enter the scoreboard on the edge that accepts them
  always @(posedge clk) begin
    cycle++;
    if (reset) begin
      q0.delete();
      q1.delete();
    end else begin
      if (b0.load && b0.ready) q0.push_back(frame(b0.z_in, b0.x_in, 1'b0));
      if (b1.load && b1.ready) q1.push_back(frame(b1.z_in, b1.x_in, 1'b1));
    end
  end
  task automatic mon(int id, int c, logic busy, logic ready, logic done, logic f);
    logic [18:0] e;
    check($sformatf("busy_n_ready%0d", id), {31'd0, busy ^ ready}, 32'd1);
    if (reset) begin
      active[id] = 1'b0;
      return;
    end
    if (!active[id] && done) check($sformatf("stray_done%0d", id), 32'd1, 32'd0);
    if (!active[id] && busy) begin
      active[id] = 1'b1;
      cyc[id] = 0;
      bits[id] = '1;
    end
    if (active[id]) begin
      if (done) begin
        n_done[id]++;
        active[id] = 1'b0;
        check($sformatf("busy_len%0d", id), cyc[id], 19 * c);
        check($sformatf("done_idle%0d", id), {30'd0, f, ready}, 32'd3);
        if ((id == 0 ? q0.size() : q1.size()) == 0) check($sformatf("unexpected_frame%0d", id), 32'd1, 32'd0);
        else begin
          if (id == 0) e = q0.pop_front();
          else e = q1.pop_front();
          check($sformatf("frame%0d", id), {13'd0, bits[id]}, {13'd0, e});
        end
      end else if (!busy) begin
        active[id] = 1'b0;
        check($sformatf("busy_drop%0d", id), 32'd1, 32'd0);
      end else begin
        if (cyc[id] % c == c / 2 && cyc[id] / c < 19) bits[id][cyc[id] / c] = f;
        cyc[id]++;
      end
    end
  endtask
  always @(negedge clk) begin
    mon(0, C0, b0.busy, b0.ready, b0.done, b0.f);
    mon(1, C1, b1.busy, b1.ready, b1.done, b1.f);
  end
  task automatic send0(logic [7:0] z, logic [7:0] x);
    @(negedge clk);
    b0.load = 1'b1;
    b0.z_in = z;
    b0.x_in = x;
    @(negedge clk);
    b0.load = 1'b0;
    b0.z_in = ~z;
    b0.x_in = ~x;
  endtask
  task automatic send1(logic [7:0] z, logic [7:0] x);
    @(negedge clk);
    b1.load = 1'b1;
    b1.z_in = z;
    b1.x_in = x;
    @(negedge clk);
    b1.load = 1'b0;
  endtask
  task automatic wait_done(int id, int n0, int lim);
    int k;
    for (k = 0; k < lim && n_done[id] <= n0; k++) @(posedge clk);
    check($sformatf("done_seen%0d", id), {31'd0, n_done[id] > n0}, 32'd1);
  endtask
  initial begin
    b0.load = 1'b0; b0.z_in = '0; b0.x_in = '0;
    b1.load = 1'b0; b1.z_in = '0; b1.x_in = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (50) begin
      @(negedge clk);
      check("idle0", {28'd0, b0.f, b0.ready, b0.busy, b0.done}, 32'hC);
    end
    nd = n_done[0]; send0(8'hA5, 8'h3C); wait_done(0, nd, 200);
    nd = n_done[0]; send0(8'h01, 8'h00); wait_done(0, nd, 200);
    nd = n_done[1]; send1(8'h01, 8'h00); wait_done(1, nd, 50);
    nd = n_done[1]; send1(8'hC3, 8'h7E); wait_done(1, nd, 50);
    nd = n_done[0];
    send0(8'h5A, 8'hC3);
    repeat (20) @(negedge clk);
    b0.load = 1'b1; b0.z_in = 8'hFF; b0.x_in = 8'hFF;
    @(negedge clk);
    b0.load = 1'b0;
    wait_done(0, nd, 200);
    repeat (100) @(negedge clk);
    check("ignored_load", n_done[0], nd + 1);
    @(negedge clk);
    b0.load = 1'b1; b0.z_in = 8'h96; b0.x_in = 8'h0F;
    for (int k = 0, n = 0; n < 3 && k < 400; k++) begin
      @(negedge clk);
      if (b0.done) begin
        t_done[n] = cycle;
        n++;
        if (n == 3) b0.load = 1'b0;
      end
    end
    b0.load = 1'b0;
    check("b2b_gap1", t_done[1] - t_done[0], 77);
    check("b2b_gap2", t_done[2] - t_done[1], 77);
    repeat (10) @(negedge clk);
    check("b2b_stop", {31'd0, b0.busy}, 32'd0);
    check("b2b_queue", q0.size(), 0);
    nd = n_done[0];
    send0(8'hE7, 8'h18);
    repeat (41) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    #1;
    check("rst_mid", {30'd0, b0.f, b0.ready}, 32'd3);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    check("rst_no_done", n_done[0], nd);
    send0(8'h42, 8'h81);
    wait_done(0, nd, 200);
    repeat (5) @(negedge clk);
    check("rst_one_done", n_done[0], nd + 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
